// File: rtl/ofs_fim_pcie_pkg.sv
// Shared PCIe FIM types: AVST TX channel record, beat type and TX protocol
// error codes used by the P-tile TX bridge.
package ofs_fim_pcie_pkg;

  localparam int NUM_AVST_CH  = 2;
  localparam int AVST_HDR_W   = 128;
  localparam int AVST_DATA_W  = 256;
  localparam int AVST_PF_W    = 3;
  localparam int AVST_VF_W    = 11;

  localparam int PCIE_TX_DEFAULT_READY_LATENCY = 3;

  typedef struct packed {
    logic                   valid;
    logic                   sop;
    logic                   eop;
    logic [AVST_HDR_W-1:0]  hdr;
    logic [AVST_DATA_W-1:0] data;
    logic                   vf_active;
    logic [AVST_PF_W-1:0]   pfn;
    logic [AVST_VF_W-1:0]   vfn;
  } t_avst_txs;

  typedef t_avst_txs [NUM_AVST_CH-1:0] t_avst_txs_beat;

  localparam int TX_BEAT_W = $bits(t_avst_txs_beat);

  typedef enum logic [1:0] {
    TX_ERR_NONE         = 2'd0,
    TX_ERR_SOP_IN_PKT   = 2'd1,
    TX_ERR_DATA_OUT_PKT = 2'd2,
    TX_ERR_EOP_NO_VALID = 2'd3
  } t_tx_err_code;

  // Header bits only carry meaning on a start-of-packet channel.
  function automatic t_avst_txs mask_hdr(input t_avst_txs ch);
    t_avst_txs r;
    r = ch;
    if (!ch.sop) r.hdr = '0;
    return r;
  endfunction

endpackage

// File: rtl/pcie_tx_fifo.sv
// Synchronous first-word-fall-through beat FIFO with occupancy count.
// Reset flushes all entries.
module pcie_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i & (count_q != CNT_FULL);
  assign do_pop  = pop_i  & (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and count registers, cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pcie_tx_bridge_ptile.sv
// FIM AXI-S TX (two TLP channels per beat) to P-tile HIP AVST TX bridge.
// Beats are buffered in a small FIFO and released only when the HIP ready,
// delayed by READY_LATENCY-1 cycles, permits a valid READY_LATENCY later.
// Optional protocol checker: define PCIE_TX_PROTO_CHK_EN.
module pcie_tx_bridge_ptile
  import ofs_fim_pcie_pkg::*;
#(
  parameter int READY_LATENCY = PCIE_TX_DEFAULT_READY_LATENCY,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                                    avl_clk,
  input  logic                                    avl_rst,
  // FIM TX stream
  input  logic                                    axis_tx_st_tvalid,
  input  logic                                    axis_tx_st_tlast,
  output logic                                    axis_tx_st_tready,
  input  logic [NUM_AVST_CH-1:0]                  axis_tx_st_valid,
  input  logic [NUM_AVST_CH-1:0]                  axis_tx_st_sop,
  input  logic [NUM_AVST_CH-1:0]                  axis_tx_st_eop,
  input  logic [NUM_AVST_CH-1:0][AVST_HDR_W-1:0]  axis_tx_st_hdr,
  input  logic [NUM_AVST_CH-1:0][AVST_DATA_W-1:0] axis_tx_st_payload,
  input  logic [NUM_AVST_CH-1:0]                  axis_tx_st_vf_active,
  input  logic [NUM_AVST_CH-1:0][AVST_PF_W-1:0]   axis_tx_st_pfn,
  input  logic [NUM_AVST_CH-1:0][AVST_VF_W-1:0]   axis_tx_st_vfn,
  // HIP AVST TX
  output logic [NUM_AVST_CH-1:0]                  avl_tx_st_valid,
  output logic [NUM_AVST_CH-1:0]                  avl_tx_st_sop,
  output logic [NUM_AVST_CH-1:0]                  avl_tx_st_eop,
  output logic [NUM_AVST_CH-1:0][AVST_HDR_W-1:0]  avl_tx_st_hdr,
  output logic [NUM_AVST_CH-1:0][AVST_DATA_W-1:0] avl_tx_st_data,
  output logic [NUM_AVST_CH-1:0]                  avl_tx_st_vf_active,
  output logic [NUM_AVST_CH-1:0][AVST_PF_W-1:0]   avl_tx_st_pfn,
  output logic [NUM_AVST_CH-1:0][AVST_VF_W-1:0]   avl_tx_st_vfn,
  input  logic                                    avl_tx_ready,
  output logic                                    tx_err,
  output logic [1:0]                              tx_err_code
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] CNT_FULL = (CW+1)'(FIFO_DEPTH);

  t_avst_txs_beat    push_beat;
  t_avst_txs_beat    fifo_rdata;
  t_avst_txs_beat    out_q;
  logic [CW:0]       fifo_count;
  logic              fifo_empty;
  logic              accept, push, pop, ready_gate;
  logic              tlast_unused;

  // tlast is always 1 on this interface and carries no information.
  assign tlast_unused = axis_tx_st_tlast;

  assign axis_tx_st_tready = ~avl_rst & (fifo_count != CNT_FULL);
  assign accept            = axis_tx_st_tvalid & axis_tx_st_tready;
  assign push              = accept & (|axis_tx_st_valid);
  assign pop               = ready_gate & ~fifo_empty;

  // Pack the incoming channels into a FIFO entry, headers kept only on sop.
  always_comb begin
    push_beat = '0;
    for (int unsigned ch = 0; ch < NUM_AVST_CH; ch++) begin
      push_beat[ch].valid     = axis_tx_st_valid[ch];
      push_beat[ch].sop       = axis_tx_st_sop[ch];
      push_beat[ch].eop       = axis_tx_st_eop[ch];
      push_beat[ch].hdr       = axis_tx_st_hdr[ch];
      push_beat[ch].data      = axis_tx_st_payload[ch];
      push_beat[ch].vf_active = axis_tx_st_vf_active[ch];
      push_beat[ch].pfn       = axis_tx_st_pfn[ch];
      push_beat[ch].vfn       = axis_tx_st_vfn[ch];
      push_beat[ch]           = mask_hdr(push_beat[ch]);
    end
  end

  pcie_tx_fifo #(
    .WIDTH (TX_BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (avl_clk),
    .rst_i   (avl_rst),
    .push_i  (push),
    .wdata_i (push_beat),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // The output register adds one cycle after the pop, so ready is delayed
  // READY_LATENCY-1 cycles to line a valid up with ready READY_LATENCY ago.
  generate
    if (READY_LATENCY == 1) begin : g_rl_direct
      assign ready_gate = avl_tx_ready;
    end else begin : g_rl_pipe
      logic [READY_LATENCY-2:0] ready_pipe_q, ready_pipe_d;
      logic [READY_LATENCY-1:0] ready_pipe_shift;

      assign ready_pipe_shift = {ready_pipe_q, avl_tx_ready};
      assign ready_pipe_d     = ready_pipe_shift[READY_LATENCY-2:0];
      assign ready_gate       = ready_pipe_q[READY_LATENCY-2];

      // Ready delay line, cleared on reset so nothing leaves early.
      always_ff @(posedge avl_clk) begin
        if (avl_rst) ready_pipe_q <= '0;
        else         ready_pipe_q <= ready_pipe_d;
      end
    end
  endgenerate

  // HIP output register: load on pop, otherwise drop the framing strobes.
  always_ff @(posedge avl_clk) begin
    if (avl_rst) begin
      out_q <= '0;
    end else if (pop) begin
      out_q <= fifo_rdata;
    end else begin
      for (int unsigned ch = 0; ch < NUM_AVST_CH; ch++) begin
        out_q[ch].valid <= 1'b0;
        out_q[ch].sop   <= 1'b0;
        out_q[ch].eop   <= 1'b0;
      end
    end
  end

  // Unpack the registered beat onto the per-field HIP ports.
  always_comb begin
    avl_tx_st_valid     = '0;
    avl_tx_st_sop       = '0;
    avl_tx_st_eop       = '0;
    avl_tx_st_hdr       = '0;
    avl_tx_st_data      = '0;
    avl_tx_st_vf_active = '0;
    avl_tx_st_pfn       = '0;
    avl_tx_st_vfn       = '0;
    for (int unsigned ch = 0; ch < NUM_AVST_CH; ch++) begin
      avl_tx_st_valid[ch]     = out_q[ch].valid;
      avl_tx_st_sop[ch]       = out_q[ch].sop;
      avl_tx_st_eop[ch]       = out_q[ch].eop;
      avl_tx_st_hdr[ch]       = out_q[ch].hdr;
      avl_tx_st_data[ch]      = out_q[ch].data;
      avl_tx_st_vf_active[ch] = out_q[ch].vf_active;
      avl_tx_st_pfn[ch]       = out_q[ch].pfn;
      avl_tx_st_vfn[ch]       = out_q[ch].vfn;
    end
  end

`ifdef PCIE_TX_PROTO_CHK_EN
  t_tx_err_code err_code_q, err_code_d, beat_err;
  logic         in_pkt_q, in_pkt_d;

  // Walk ch0 then ch1 of an accepted beat, tracking packet state and
  // noting the first violation seen in the beat.
  always_comb begin
    in_pkt_d = in_pkt_q;
    beat_err = TX_ERR_NONE;
    if (accept) begin
      for (int unsigned ch = 0; ch < NUM_AVST_CH; ch++) begin
        if (!axis_tx_st_valid[ch]) begin
          if (axis_tx_st_eop[ch] && beat_err == TX_ERR_NONE)
            beat_err = TX_ERR_EOP_NO_VALID;
        end else begin
          if (beat_err == TX_ERR_NONE) begin
            if (axis_tx_st_sop[ch] && in_pkt_d)
              beat_err = TX_ERR_SOP_IN_PKT;
            else if (!axis_tx_st_sop[ch] && !in_pkt_d)
              beat_err = TX_ERR_DATA_OUT_PKT;
          end
          if (axis_tx_st_sop[ch]) in_pkt_d = 1'b1;
          if (axis_tx_st_eop[ch]) in_pkt_d = 1'b0;
        end
      end
    end
    err_code_d = (err_code_q == TX_ERR_NONE) ? beat_err : err_code_q;
  end

  // Packet state and sticky first-error register.
  always_ff @(posedge avl_clk) begin
    if (avl_rst) begin
      in_pkt_q   <= 1'b0;
      err_code_q <= TX_ERR_NONE;
    end else begin
      in_pkt_q   <= in_pkt_d;
      err_code_q <= err_code_d;
    end
  end

  assign tx_err      = (err_code_q != TX_ERR_NONE);
  assign tx_err_code = err_code_q;
`else
  assign tx_err      = 1'b0;
  assign tx_err_code = '0;
`endif

endmodule

// File: tb/tb_pcie_tx_bridge_ptile.sv
// Directed bench for pcie_tx_bridge_ptile: vector table for single beats,
// plus hand sequences for ready toggling, backpressure, reset and errors.
`timescale 1ns/1ps
module tb_pcie_tx_bridge_ptile;
  import ofs_fim_pcie_pkg::*;

  localparam int RL    = 3;
  localparam int DEPTH = 8;
`ifdef PCIE_TX_PROTO_CHK_EN
  localparam logic       EXP_ERR  = 1'b1;
  localparam logic [1:0] EXP_CODE = 2'd1;
`else
  localparam logic       EXP_ERR  = 1'b0;
  localparam logic [1:0] EXP_CODE = 2'd0;
`endif

  typedef struct packed {
    logic [1:0]                  v, s, e;
    logic [1:0][AVST_HDR_W-1:0]  hdr;
    logic [1:0][AVST_DATA_W-1:0] data;
    logic [1:0]                  vfa;
    logic [1:0][AVST_PF_W-1:0]   pfn;
    logic [1:0][AVST_VF_W-1:0]   vfn;
  } tb_beat_t;

  typedef struct {
    logic       tv;
    logic [1:0] v, s, e;
    logic [1:0] xv, xs, xe;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_tvalid = 1'b0;
  logic tready;
  logic [1:0] in_valid = '0, in_sop = '0, in_eop = '0, in_vfa = '0;
  logic [1:0][AVST_HDR_W-1:0]  in_hdr = '0;
  logic [1:0][AVST_DATA_W-1:0] in_payload = '0;
  logic [1:0][AVST_PF_W-1:0]   in_pfn = '0;
  logic [1:0][AVST_VF_W-1:0]   in_vfn = '0;
  logic [1:0] o_valid, o_sop, o_eop, o_vfa;
  logic [1:0][AVST_HDR_W-1:0]  o_hdr;
  logic [1:0][AVST_DATA_W-1:0] o_data;
  logic [1:0][AVST_PF_W-1:0]   o_pfn;
  logic [1:0][AVST_VF_W-1:0]   o_vfn;
  logic avl_tx_ready = 1'b1;
  logic tx_err;
  logic [1:0] tx_err_code;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pcie_tx_bridge_ptile #(
    .READY_LATENCY (RL),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .avl_clk              (clk),
    .avl_rst              (rst),
    .axis_tx_st_tvalid    (in_tvalid),
    .axis_tx_st_tlast     (1'b1),
    .axis_tx_st_tready    (tready),
    .axis_tx_st_valid     (in_valid),
    .axis_tx_st_sop       (in_sop),
    .axis_tx_st_eop       (in_eop),
    .axis_tx_st_hdr       (in_hdr),
    .axis_tx_st_payload   (in_payload),
    .axis_tx_st_vf_active (in_vfa),
    .axis_tx_st_pfn       (in_pfn),
    .axis_tx_st_vfn       (in_vfn),
    .avl_tx_st_valid      (o_valid),
    .avl_tx_st_sop        (o_sop),
    .avl_tx_st_eop        (o_eop),
    .avl_tx_st_hdr        (o_hdr),
    .avl_tx_st_data       (o_data),
    .avl_tx_st_vf_active  (o_vfa),
    .avl_tx_st_pfn        (o_pfn),
    .avl_tx_st_vfn        (o_vfn),
    .avl_tx_ready         (avl_tx_ready),
    .tx_err               (tx_err),
    .tx_err_code          (tx_err_code)
  );

  function automatic tb_beat_t mk_beat(input int tag, input logic [1:0] v, s, e);
    tb_beat_t b;
    logic [15:0] t;
    t = tag[15:0];
    b.v = v; b.s = s; b.e = e;
    b.hdr[0]  = {8{t ^ 16'hA000}};
    b.hdr[1]  = {8{t ^ 16'h5111}};
    b.data[0] = {16{t}};
    b.data[1] = {16{t ^ 16'hFFFF}};
    b.vfa     = {t[0], ~t[0]};
    b.pfn[0]  = t[2:0];
    b.pfn[1]  = t[5:3];
    b.vfn[0]  = t[10:0];
    b.vfn[1]  = t[15:5];
    return b;
  endfunction

  function automatic tb_beat_t exp_of(input tb_beat_t b);
    tb_beat_t x;
    x = b;
    for (int c = 0; c < 2; c++) if (!b.s[c]) x.hdr[c] = '0;
    return x;
  endfunction

  function automatic tb_beat_t read_out();
    tb_beat_t b;
    b.v = o_valid; b.s = o_sop; b.e = o_eop;
    b.hdr = o_hdr; b.data = o_data; b.vfa = o_vfa; b.pfn = o_pfn; b.vfn = o_vfn;
    return b;
  endfunction

  task automatic drive(input tb_beat_t b, input logic tv);
    in_tvalid = tv; in_valid = b.v; in_sop = b.s; in_eop = b.e;
    in_hdr = b.hdr; in_payload = b.data; in_vfa = b.vfa; in_pfn = b.pfn; in_vfn = b.vfn;
  endtask

  task automatic idle();
    in_tvalid = 1'b0; in_valid = '0; in_sop = '0; in_eop = '0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_beat(input string name, input tb_beat_t act, input tb_beat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b s=%b e=%b d0=%h d1=%h h0=%h h1=%h pf=%h vf=%h want v=%b s=%b e=%b d0=%h d1=%h h0=%h h1=%h pf=%h vf=%h",
               name, act.v, act.s, act.e, act.data[0][31:0], act.data[1][31:0],
               act.hdr[0][31:0], act.hdr[1][31:0], act.pfn, act.vfn,
               exp.v, exp.s, exp.e, exp.data[0][31:0], exp.data[1][31:0],
               exp.hdr[0][31:0], exp.hdr[1][31:0], exp.pfn, exp.vfn);
    end
  endtask

  // Ready history and output collector with HIP ready-latency contract check.
  int       pcount = 0;
  bit       rh [0:8191];
  bit       mon_en = 1'b0;
  int       viol = 0;
  tb_beat_t got[$];

  always @(posedge clk) begin
    if (pcount < 8192) rh[pcount] = avl_tx_ready;
    pcount++;
  end

  always @(negedge clk) begin
    if (mon_en && (o_valid != 2'b00)) begin
      if (pcount >= RL && pcount - RL < 8192 && !rh[pcount - RL]) viol++;
      got.push_back(read_out());
    end
  end

  task automatic wait_got(input int n, input int max_cyc);
    for (int k = 0; k < max_cyc && got.size() < n; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  vec_t     tbl [8];
  tb_beat_t b, o;
  int       sent, acc, base;

  initial begin
    tbl[0] = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    tbl[1] = '{1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    tbl[2] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[3] = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    tbl[4] = '{1'b1, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    tbl[5] = '{1'b1, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    tbl[6] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    tbl[7] = '{1'b1, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b10};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tready", tready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_sop_eop", {o_sop, o_eop}, 0);
    check("rst_err", {tx_err, tx_err_code}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_tready", tready, 1);
    mon_en = 1'b1;

    // Single-beat vectors, ready held high: output exactly 2 cycles later
    for (int i = 0; i < 8; i++) begin
      b = mk_beat(100 + i, tbl[i].v, tbl[i].s, tbl[i].e);
      @(negedge clk);
      drive(b, tbl[i].tv);
      #1 check("vec_tready", tready, 1);
      @(negedge clk);
      idle();
      check("vec_early", o_valid, 0);
      @(negedge clk);
      o = read_out();
      check("vec_masks", {o.v, o.s, o.e}, {tbl[i].xv, tbl[i].xs, tbl[i].xe});
      if (tbl[i].xv != 2'b00) check_beat("vec_beat", o, exp_of(b));
      @(negedge clk);
      check("vec_after", o_valid, 0);
    end
    got.delete();

    // 20-beat stream with ready dropping one cycle in five
    sent = 0;
    for (int k = 0; k < 200 && sent < 20; k++) begin
      @(negedge clk);
      avl_tx_ready = (k % 5 != 4);
      drive(mk_beat(200 + sent, 2'b11, 2'b11, 2'b11), 1'b1);
      #1 if (tready) sent++;
    end
    @(negedge clk);
    idle();
    avl_tx_ready = 1'b1;
    wait_got(20, 60);
    check("stream_sent", sent, 20);
    check("stream_count", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++)
      check_beat("stream_beat", got[i], exp_of(mk_beat(200 + i, 2'b11, 2'b11, 2'b11)));
    check("stream_hip_contract", viol, 0);
    got.delete();

    // Ready held low with continuous input: FIFO fills and stalls upstream
    @(negedge clk);
    avl_tx_ready = 1'b0;
    idle();
    repeat (4) @(negedge clk);
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(mk_beat(300 + acc, 2'b01, 2'b01, 2'b01), 1'b1);
      #1 if (tready) acc++;
    end
    check("bp_accepted", acc, DEPTH);
    check("bp_tready_low", tready, 0);
    check("bp_no_output", got.size(), 0);
    for (int k = 0; k < 100 && acc < 14; k++) begin
      @(negedge clk);
      avl_tx_ready = 1'b1;
      drive(mk_beat(300 + acc, 2'b01, 2'b01, 2'b01), 1'b1);
      #1 if (tready) acc++;
    end
    @(negedge clk);
    idle();
    wait_got(14, 60);
    check("bp_total", got.size(), 14);
    for (int i = 0; i < 14 && i < got.size(); i++)
      check_beat("bp_beat", got[i], exp_of(mk_beat(300 + i, 2'b01, 2'b01, 2'b01)));
    check("bp_hip_contract", viol, 0);
    got.delete();

    // Reset in the middle of a 4-beat TLP
    @(negedge clk);
    avl_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    drive(mk_beat(350, 2'b11, 2'b01, 2'b00), 1'b1);
    @(negedge clk);
    drive(mk_beat(351, 2'b11, 2'b00, 2'b00), 1'b1);
    @(negedge clk);
    drive(mk_beat(352, 2'b11, 2'b00, 2'b00), 1'b1);
    @(negedge clk);
    idle();
    avl_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_pre_valid", {o_valid, o_sop}, {2'b11, 2'b01});
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_tready", tready, 0);
    rst = 1'b0;
    base = got.size();
    repeat (8) @(negedge clk);
    check("mid_flushed", got.size(), base);
    drive(mk_beat(400, 2'b01, 2'b01, 2'b01), 1'b1);
    @(negedge clk);
    idle();
    wait_got(base + 1, 20);
    check("post_rst_count", got.size(), base + 1);
    if (got.size() > base)
      check_beat("post_rst_beat", got[base], exp_of(mk_beat(400, 2'b01, 2'b01, 2'b01)));
    check("clean_no_err", {tx_err, tx_err_code}, 0);

    // Protocol errors: sop on ch1 inside ch0 packet, then eop without valid
    @(negedge clk);
    drive(mk_beat(500, 2'b11, 2'b11, 2'b00), 1'b1);
    @(negedge clk);
    drive(mk_beat(501, 2'b00, 2'b00, 2'b01), 1'b1);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("err_flag", tx_err, EXP_ERR);
    check("err_code_sticky", tx_err_code, EXP_CODE);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("err_cleared", {tx_err, tx_err_code}, 0);
    check("final_hip_contract", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
